// File: rtl/vram_arb_pkg.sv
// Package vram_arb_pkg
// Purpose: shared types and constants for the VRAM write arbiter.
//   state_t    : top-level sequencer state (idle arbitration / clear fill)
//   req_id_t   : requester identity, also the bit index of each requester
//                in the 2-bit request/grant vectors (bit 0 = KB, bit 1 = CPU)
//   FILL_CHAR_DEFAULT : blank word written by the clear sequence (ASCII space)
package vram_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        REQ_KB  = 1'b0,
        REQ_CPU = 1'b1
    } req_id_t;

    localparam logic [15:0] FILL_CHAR_DEFAULT = 16'h0020;

endpackage

// File: rtl/rr_arbiter2.sv
// Module rr_arbiter2
// Purpose: two-input round-robin arbiter. The grant is combinational and
//   one-hot; the caller registers it. rr_last remembers the most recent
//   winner so that on a conflict the other requester is served.
// Ports:
//   clk     in  1  clock
//   rst     in  1  asynchronous active-high reset (rr_last -> CPU, so the
//                  keyboard wins the first conflict)
//   enable  in  1  arbitration allowed this cycle; no grant and no rr_last
//                  update when low
//   req     in  2  request vector, indexed by req_id_t
//   gnt     out 2  one-hot grant vector, indexed by req_id_t
module rr_arbiter2
    import vram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_t rr_last_reg;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                // Conflict: serve whoever did not win last time.
                if (rr_last_reg == REQ_CPU) begin
                    gnt[REQ_KB] = 1'b1;
                end else begin
                    gnt[REQ_CPU] = 1'b1;
                end
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_reg <= REQ_CPU;
        end else if (|gnt) begin
            rr_last_reg <= gnt[REQ_CPU] ? REQ_CPU : REQ_KB;
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Module vram_write_arbiter
// Purpose: shares the single write port of the display blockram between the
//   keyboard echo writer and the CPU result writer (2-way round robin, one
//   write per cycle), and optionally fills the whole RAM with FILL_CHAR.
// Build option: define VRAM_WR_ARB_CLEAR_EN to include the clear sequencer.
//   Without it there is no clear state or counter, clr_start is ignored and
//   clr_busy/clr_done stay 0.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   kb_req/addr/data    keyboard write request (held until kb_gnt)
//   kb_gnt              1-cycle pulse, keyboard write committed
//   cpu_req/addr/data   CPU write request (held until cpu_gnt)
//   cpu_gnt             1-cycle pulse, CPU write committed
//   clr_start           pulse, begin full-RAM clear
//   clr_busy            high during the cycles carrying clear writes
//   clr_done            1-cycle pulse after the last clear write
//   ram_addr_w, ram_wr_enable, ram_data_in   blockram write port
// All outputs are registered; a request sampled at edge N shows up as a
// grant plus RAM write in the cycle following edge N.
module vram_write_arbiter
    import vram_arb_pkg::*;
#(
    parameter int                WIDTH     = 16,
    parameter int                DEPTH     = 12,
    parameter logic [WIDTH-1:0]  FILL_CHAR = WIDTH'(FILL_CHAR_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kb_req,
    input  logic [DEPTH-1:0] kb_addr,
    input  logic [WIDTH-1:0] kb_data,
    output logic             kb_gnt,
    input  logic             cpu_req,
    input  logic [DEPTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_data,
    output logic             cpu_gnt,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             clr_done,
    output logic [DEPTH-1:0] ram_addr_w,
    output logic             ram_wr_enable,
    output logic [WIDTH-1:0] ram_data_in
);

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       arb_en;

    assign arb_req[REQ_KB]  = kb_req;
    assign arb_req[REQ_CPU] = cpu_req;

`ifdef VRAM_WR_ARB_CLEAR_EN
    // Counter is one bit wider than the address so that reaching 2**DEPTH
    // (all words written) is an explicit terminal value, not a wrap to 0.
    localparam logic [DEPTH:0] CLR_END = {1'b1, {DEPTH{1'b0}}};

    state_t           state_reg;
    logic [DEPTH:0]   clr_cnt_reg;

    // A clear request in IDLE takes priority over any pending write.
    assign arb_en = (state_reg == ST_IDLE) && !clr_start;
`else
    logic unused_clr_start;

    assign unused_clr_start = clr_start;
    assign arb_en   = 1'b1;
    assign clr_busy = 1'b0;
    assign clr_done = 1'b0;
`endif

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .enable (arb_en),
        .req    (arb_req),
        .gnt    (arb_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_gnt        <= 1'b0;
            cpu_gnt       <= 1'b0;
            ram_wr_enable <= 1'b0;
            ram_addr_w    <= '0;
            ram_data_in   <= '0;
`ifdef VRAM_WR_ARB_CLEAR_EN
            state_reg     <= ST_IDLE;
            clr_cnt_reg   <= '0;
            clr_busy      <= 1'b0;
            clr_done      <= 1'b0;
`endif
        end else begin
            // Arbitrated write; arb_gnt is zero whenever the clear owns the port.
            kb_gnt        <= arb_gnt[REQ_KB];
            cpu_gnt       <= arb_gnt[REQ_CPU];
            ram_wr_enable <= |arb_gnt;
            if (arb_gnt[REQ_CPU]) begin
                ram_addr_w  <= cpu_addr;
                ram_data_in <= cpu_data;
            end else if (arb_gnt[REQ_KB]) begin
                ram_addr_w  <= kb_addr;
                ram_data_in <= kb_data;
            end
`ifdef VRAM_WR_ARB_CLEAR_EN
            clr_done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (clr_start) begin
                        state_reg   <= ST_CLEAR;
                        clr_cnt_reg <= '0;
                    end
                end
                ST_CLEAR: begin
                    // clr_start is deliberately not looked at here: no restart.
                    if (clr_cnt_reg == CLR_END) begin
                        state_reg <= ST_IDLE;
                        clr_busy  <= 1'b0;
                        clr_done  <= 1'b1;
                    end else begin
                        ram_wr_enable <= 1'b1;
                        ram_addr_w    <= clr_cnt_reg[DEPTH-1:0];
                        ram_data_in   <= FILL_CHAR;
                        clr_busy      <= 1'b1;
                        clr_cnt_reg   <= clr_cnt_reg + 1'b1;
                    end
                end
            endcase
`endif
        end
    end

endmodule
